vq_tag_encoder: RTL and testbench

- Vector-quantisation compressor: replaces each 24-bit RGB pixel of an image with the 6-bit index of its nearest codebook colour.
- Reads the codebook and the image from source memory RAM1 and writes one tag word per pixel to destination memory RAM2.
- Sits between two single-port RAM instances (CK, A[19:0], WE, OE, D[23:0], Q[23:0]) and raises done when the compressed image is complete.

---
 rtl/vq_pkg.sv | 30 +++
 rtl/vq_dist_lane.sv | 33 +++
 rtl/vq_tag_encoder.sv | 247 ++++++++++++++++++++++++
 tb/tb_vq_tag_encoder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vq_pkg.sv
// Shared configuration, types and helpers for the vector-quantisation tag encoder.
package vq_pkg;

  localparam int unsigned CB_SIZE   = 64;        // codebook entries
  localparam int unsigned PIX_COUNT = 4096;      // image pixels
  localparam int unsigned CB_BASE   = 0;         // first codebook word in RAM1
  localparam int unsigned PIX_BASE  = CB_SIZE;   // first pixel word in RAM1
  localparam int unsigned RGB_W     = 24;
  localparam int unsigned DIST_W    = 18;        // 3 * 255^2 = 195075 fits in 18 bits
  localparam int unsigned IDX_W     = 6;         // log2(CB_SIZE)
  localparam int unsigned ADDR_W    = 20;

  typedef enum logic [1:0] {
    LOAD_CB = 2'd0,
    SEARCH  = 2'd1,
    DONE    = 2'd2
  } vq_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Magnitude of the difference of two colour channels.
  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/vq_dist_lane.sv
// Squared Euclidean RGB distance between one pixel and one codeword (combinational).
module vq_dist_lane
  import vq_pkg::*;
(
  input  logic [RGB_W-1:0]  pix_i,
  input  logic [RGB_W-1:0]  cw_i,
  output logic [DIST_W-1:0] dist_o
);

  rgb_t        pix;
  rgb_t        cw;
  logic [7:0]  dr;
  logic [7:0]  dg;
  logic [7:0]  db;
  logic [15:0] sr;
  logic [15:0] sg;
  logic [15:0] sb;

  assign pix = rgb_t'(pix_i);
  assign cw  = rgb_t'(cw_i);

  assign dr = abs_diff(pix.r, cw.r);
  assign dg = abs_diff(pix.g, cw.g);
  assign db = abs_diff(pix.b, cw.b);

  // Full-width squares and sum: no truncation anywhere in the distance.
  assign sr = {8'd0, dr} * {8'd0, dr};
  assign sg = {8'd0, dg} * {8'd0, dg};
  assign sb = {8'd0, db} * {8'd0, db};

  assign dist_o = {2'b00, sr} + {2'b00, sg} + {2'b00, sb};

endmodule

// File: rtl/vq_tag_encoder.sv
// Vector-quantisation encoder: loads a codebook from RAM1, then replaces every
// image pixel with the index of its nearest codeword, written to RAM2.
// LANES codewords are compared per cycle; LANES must divide CB_SIZE.
module vq_tag_encoder
  import vq_pkg::*;
#(
  parameter int unsigned LANES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] RAM1_Q,
  output logic [23:0] RAM1_D,
  output logic [19:0] RAM1_A,
  output logic        RAM1_WE,
  output logic        RAM1_OE,
  output logic [23:0] RAM2_D,
  output logic [19:0] RAM2_A,
  output logic        RAM2_WE,
  output logic        RAM2_OE,
  output logic        done
);

  localparam int unsigned GROUPS = CB_SIZE / LANES;
  localparam int unsigned GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int unsigned CNT_W  = $clog2(CB_SIZE + PIX_COUNT + 1);
  localparam int unsigned PIX_W  = $clog2(PIX_COUNT);

  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(CB_BASE);
  localparam logic [CNT_W-1:0] CNT_PIX   = CNT_W'(PIX_BASE);
  localparam logic [CNT_W-1:0] CNT_END   = CNT_W'(CB_SIZE + PIX_COUNT);
  localparam logic [IDX_W-1:0] CB_LAST   = IDX_W'(CB_SIZE - 1);
  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(PIX_COUNT - 1);
  localparam logic [GRP_W-1:0] GRP_LAST  = GRP_W'(GROUPS - 1);

  // Control state
  vq_state_e state_q, state_d;

  // Read issue stage (drives RAM1 directly)
  logic [CNT_W-1:0]  iss_q, iss_d;         // next RAM1 word to fetch
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic              roe_q, roe_d;
  logic              rpix_q, rpix_d;       // issued read targets a pixel

  // Read return stage (RAM1_Q valid while qv_q is high)
  logic              qv_q, qv_d;
  logic              qpix_q, qpix_d;
  logic [IDX_W-1:0]  qidx_q, qidx_d;

  // One-entry prefetch buffer for the next pixel
  logic [RGB_W-1:0]  nxt_q, nxt_d;
  logic              nxt_vld_q, nxt_vld_d;

  // Search stage
  logic [RGB_W-1:0]  cur_q, cur_d;
  logic              busy_q, busy_d;
  logic [GRP_W-1:0]  grp_q, grp_d;
  logic [PIX_W-1:0]  pix_q, pix_d;         // number of the pixel being searched
  logic [DIST_W-1:0] best_dist_q, best_dist_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;

  // Write stage (drives RAM2 directly)
  logic              we_q, we_d;
  logic [PIX_W-1:0]  wa_q, wa_d;
  logic [IDX_W-1:0]  wd_q, wd_d;

  // Codebook register file
  logic [RGB_W-1:0]  cb_q [CB_SIZE];

  // Datapath helpers
  logic              pix_slot_free;
  logic              iss_is_pix;
  logic              issue;
  logic              last_grp;
  logic              start;
  logic [IDX_W-1:0]  lane_idx  [LANES];
  logic [DIST_W-1:0] lane_dist [LANES];
  logic [DIST_W-1:0] grp_dist;
  logic [IDX_W-1:0]  grp_idx;
  logic              take_grp;
  logic [DIST_W-1:0] run_dist;
  logic [IDX_W-1:0]  run_idx;

  // Only one pixel may be buffered or in flight, so the prefetch never overruns.
  assign pix_slot_free = !nxt_vld_q && !(roe_q && rpix_q) && !(qv_q && qpix_q);
  assign iss_is_pix    = (iss_q >= CNT_PIX);
  assign issue         = (state_q != DONE) && (iss_q < CNT_END) &&
                         (!iss_is_pix || pix_slot_free);
  assign last_grp      = (grp_q == GRP_LAST);
  assign start         = (state_q == SEARCH) && nxt_vld_q && (!busy_q || last_grp);

  // Distance lanes: lane l of group g compares codeword g*LANES + l.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l] = IDX_W'(grp_q * LANES + l);

    vq_dist_lane u_lane (
      .pix_i  (cur_q),
      .cw_i   (cb_q[lane_idx[l]]),
      .dist_o (lane_dist[l])
    );
  end

  // Min/argmin over the lanes of this group; strict < keeps the lowest index on ties.
  always_comb begin
    // NOTE: blocking assignments here are intentional: each loop step reads the previous step's result.
    grp_dist = lane_dist[0];
    grp_idx  = lane_idx[0];
    for (int l = 1; l < LANES; l++) begin
      if (lane_dist[l] < grp_dist) begin
        grp_dist = lane_dist[l];
        grp_idx  = lane_idx[l];
      end
    end
  end

  // Earlier groups hold lower indices, so again only a strictly smaller distance replaces them.
  assign take_grp = (grp_q == '0) || (grp_dist < best_dist_q);
  assign run_dist = take_grp ? grp_dist : best_dist_q;
  assign run_idx  = take_grp ? grp_idx  : best_idx_q;

  // FSM next state and completion flag.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      LOAD_CB: if (qv_q && !qpix_q && (qidx_q == CB_LAST)) state_d = SEARCH;
      SEARCH:  if (we_q && (wa_q == PIX_LAST)) state_d = DONE;
      DONE:    done = 1'b1;
      default: state_d = LOAD_CB;
    endcase
  end

  // Datapath next state: read issue, read return, prefetch, search and write.
  always_comb begin
    // NOTE: every _d starts from a hold value so no path through this block can infer a latch.
    iss_d       = iss_q;
    ra_d        = ra_q;
    roe_d       = 1'b0;
    rpix_d      = 1'b0;
    qv_d        = roe_q;
    qpix_d      = rpix_q;
    qidx_d      = ra_q[IDX_W-1:0];
    nxt_d       = nxt_q;
    nxt_vld_d   = nxt_vld_q;
    cur_d       = cur_q;
    busy_d      = busy_q;
    grp_d       = grp_q;
    pix_d       = pix_q;
    best_dist_d = best_dist_q;
    best_idx_d  = best_idx_q;
    we_d        = 1'b0;
    wa_d        = wa_q;
    wd_d        = wd_q;

    if (issue) begin
      ra_d   = ADDR_W'(iss_q);
      roe_d  = 1'b1;
      rpix_d = iss_is_pix;
      iss_d  = iss_q + 1'b1;
    end

    if (busy_q) begin
      best_dist_d = run_dist;
      best_idx_d  = run_idx;
      grp_d       = grp_q + 1'b1;
      if (last_grp) begin
        we_d   = 1'b1;
        wa_d   = pix_q;
        wd_d   = run_idx;
        busy_d = 1'b0;
        pix_d  = pix_q + 1'b1;
      end
    end

    if (start) begin
      cur_d     = nxt_q;
      nxt_vld_d = 1'b0;
      busy_d    = 1'b1;
      grp_d     = '0;
    end

    if (qv_q && qpix_q) begin
      nxt_d     = RAM1_Q;
      nxt_vld_d = 1'b1;
    end
  end

  // State and datapath registers; reset aborts everything and restarts from LOAD_CB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LOAD_CB;
      iss_q       <= CNT_START;
      ra_q        <= '0;
      roe_q       <= 1'b0;
      rpix_q      <= 1'b0;
      qv_q        <= 1'b0;
      qpix_q      <= 1'b0;
      qidx_q      <= '0;
      nxt_q       <= '0;
      nxt_vld_q   <= 1'b0;
      cur_q       <= '0;
      busy_q      <= 1'b0;
      grp_q       <= '0;
      pix_q       <= '0;
      best_dist_q <= '0;
      best_idx_q  <= '0;
      we_q        <= 1'b0;
      wa_q        <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      iss_q       <= iss_d;
      ra_q        <= ra_d;
      roe_q       <= roe_d;
      rpix_q      <= rpix_d;
      qv_q        <= qv_d;
      qpix_q      <= qpix_d;
      qidx_q      <= qidx_d;
      nxt_q       <= nxt_d;
      nxt_vld_q   <= nxt_vld_d;
      cur_q       <= cur_d;
      busy_q      <= busy_d;
      grp_q       <= grp_d;
      pix_q       <= pix_d;
      best_dist_q <= best_dist_d;
      best_idx_q  <= best_idx_d;
      we_q        <= we_d;
      wa_q        <= wa_d;
      wd_q        <= wd_d;
    end
  end

  // Codebook capture: each returned non-pixel word lands in its codebook slot.
  // NOTE: the codebook array is not reset; it is completely rewritten before any search reads it.
  always_ff @(posedge clk) begin
    if (qv_q && !qpix_q) cb_q[qidx_q] <= RAM1_Q;
  end

  assign RAM1_D  = '0;
  assign RAM1_WE = 1'b0;
  assign RAM1_A  = ra_q;
  assign RAM1_OE = roe_q;
  assign RAM2_D  = {{(RGB_W - IDX_W){1'b0}}, wd_q};
  assign RAM2_A  = ADDR_W'(wa_q);
  assign RAM2_WE = we_q;
  assign RAM2_OE = 1'b0;

endmodule

// File: tb/tb_vq_tag_encoder.sv
// Scoreboard bench for vq_tag_encoder: behavioural RAMs, a nearest-colour
// reference model, and a monitor that checks every RAM2 write in order.
module tb_vq_tag_encoder;
  import vq_pkg::*;

  localparam int TOTAL = CB_SIZE + PIX_COUNT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] RAM1_Q = '0;
  logic [23:0] RAM1_D;
  logic [19:0] RAM1_A;
  logic        RAM1_WE;
  logic        RAM1_OE;
  logic [23:0] RAM2_D;
  logic [19:0] RAM2_A;
  logic        RAM2_WE;
  logic        RAM2_OE;
  logic        done;

  logic [23:0] ram1 [TOTAL];
  logic [23:0] ram2 [PIX_COUNT];

  typedef struct {
    int         addr;
    logic [5:0] tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [5:0]  gold [PIX_COUNT];

  int n_cmp = 0;
  int n_err = 0;
  int bad_tie = 0;
  int bad_addr = 0;
  int bad_after_done = 0;

  always #5 clk = ~clk;

  vq_tag_encoder dut (
    .clk     (clk),
    .rst     (rst),
    .RAM1_Q  (RAM1_Q),
    .RAM1_D  (RAM1_D),
    .RAM1_A  (RAM1_A),
    .RAM1_WE (RAM1_WE),
    .RAM1_OE (RAM1_OE),
    .RAM2_D  (RAM2_D),
    .RAM2_A  (RAM2_A),
    .RAM2_WE (RAM2_WE),
    .RAM2_OE (RAM2_OE),
    .done    (done)
  );

  // Synchronous single-port RAMs with one-cycle read latency.
  always @(posedge clk) begin
    if (RAM1_OE) RAM1_Q <= (int'(RAM1_A) < TOTAL) ? ram1[RAM1_A] : 24'h0;
    if (RAM2_WE && int'(RAM2_A) < PIX_COUNT) ram2[RAM2_A] <= RAM2_D;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exhaustive nearest codeword by plain integer arithmetic, first index wins ties.
  function automatic logic [5:0] nearest(input logic [23:0] p);
    int best_d;
    int best_i;
    best_d = 1 << 30;
    best_i = 0;
    for (int i = 0; i < CB_SIZE; i++) begin
      int dr;
      int dg;
      int db;
      int d;
      dr = int'(p[23:16]) - int'(ram1[i][23:16]);
      dg = int'(p[15:8])  - int'(ram1[i][15:8]);
      db = int'(p[7:0])   - int'(ram1[i][7:0]);
      d  = dr * dr + dg * dg + db * db;
      if (d < best_d) begin
        best_d = d;
        best_i = i;
      end
    end
    return 6'(best_i);
  endfunction

  // Monitor: every RAM2 write is popped against the scoreboard.
  always @(negedge clk) begin
    if (rst && RAM2_WE) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL ram2_unexpected_write: addr %0d data 0x%0h with empty scoreboard", RAM2_A, RAM2_D);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ram2_addr", 32'(RAM2_A), 32'(e.addr));
        check("ram2_tag", 32'(RAM2_D), {26'd0, e.tag});
      end
    end
  end

  // Protocol watch: tied outputs, address range, silence after done.
  always @(negedge clk) begin
    if (rst) begin
      if (RAM1_WE !== 1'b0 || RAM1_D !== 24'h0 || RAM2_OE !== 1'b0) bad_tie++;
      if (RAM1_OE && int'(RAM1_A) >= TOTAL) bad_addr++;
      if (RAM2_WE && int'(RAM2_A) >= PIX_COUNT) bad_addr++;
      if (done && (RAM1_OE || RAM2_WE)) bad_after_done++;
    end
  end

  // Hold reset, verify reset outputs, load expectations, release and check the first reads.
  task automatic start_run(input string tag);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_rst_done"},    32'(done),    32'd0);
    check({tag, "_rst_ram2_we"}, 32'(RAM2_WE), 32'd0);
    check({tag, "_rst_ram1_we"}, 32'(RAM1_WE), 32'd0);
    check({tag, "_rst_ram1_oe"}, 32'(RAM1_OE), 32'd0);
    exp_q.delete();
    bad_tie = 0;
    bad_addr = 0;
    bad_after_done = 0;
    for (int j = 0; j < PIX_COUNT; j++) begin
      gold[j] = nearest(ram1[CB_SIZE + j]);
      exp_q.push_back('{addr: j, tag: gold[j]});
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check({tag, "_first_ram1_a"},  32'(RAM1_A),  32'(k));
      check({tag, "_first_ram1_oe"}, 32'(RAM1_OE), 32'd1);
    end
  endtask

  // Let n_pix tags be written, then stop with a reset.
  task automatic run_partial(input string tag, input int n_pix);
    int cyc;
    cyc = 0;
    while (exp_q.size() > PIX_COUNT - n_pix && cyc < n_pix * 12 + 300) begin
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() > PIX_COUNT - n_pix) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_progress_timeout: %0d tags written, wanted %0d", tag, PIX_COUNT - exp_q.size(), n_pix);
    end
    check({tag, "_tied_outputs"}, 32'(bad_tie), 32'd0);
    check({tag, "_addr_range"},   32'(bad_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int drops;
    for (int j = 0; j < PIX_COUNT; j++) ram2[j] = 24'hFFFFFF;

    // Exact match: cb[i] = {4i,4i,4i}, grey 0x949494 maps to index 37.
    for (int i = 0; i < CB_SIZE; i++) ram1[i] = {8'(4 * i), 8'(4 * i), 8'(4 * i)};
    for (int j = 0; j < PIX_COUNT; j++) ram1[CB_SIZE + j] = 24'h949494;
    start_run("exact");
    run_partial("exact", 150);

    // Tie-break: duplicated codeword at 5 and 9, everything else white.
    for (int i = 0; i < CB_SIZE; i++) ram1[i] = 24'hFFFFFF;
    ram1[5] = 24'h102030;
    ram1[9] = 24'h102030;
    for (int j = 0; j < PIX_COUNT; j++)
      ram1[CB_SIZE + j] = (j % 3 == 0) ? 24'($urandom) : 24'h102030;
    start_run("tie");
    run_partial("tie", 150);

    // Extremes: full-scale pixels against near-extreme codewords.
    for (int i = 0; i < CB_SIZE; i++) ram1[i] = 24'h808080;
    ram1[0]  = 24'h000000;
    ram1[63] = 24'hFEFFFF;
    for (int j = 0; j < PIX_COUNT; j++) begin
      case (j % 4)
        0: ram1[CB_SIZE + j] = 24'hFFFFFF;
        1: ram1[CB_SIZE + j] = 24'h000000;
        2: ram1[CB_SIZE + j] = 24'hFF00FF;
        default: ram1[CB_SIZE + j] = 24'($urandom);
      endcase
    end
    start_run("extreme");
    run_partial("extreme", 150);

    // Full image with a random codebook (some duplicated codewords and exact hits).
    for (int i = 0; i < CB_SIZE; i++) ram1[i] = 24'($urandom);
    ram1[20] = ram1[11];
    ram1[47] = ram1[3];
    for (int j = 0; j < PIX_COUNT; j++) begin
      if (j % 7 == 0) ram1[CB_SIZE + j] = ram1[$urandom_range(CB_SIZE - 1, 0)];
      else            ram1[CB_SIZE + j] = 24'($urandom);
    end
    for (int j = 0; j < PIX_COUNT; j++) ram2[j] = 24'hFFFFFF;

    // Abort around pixel 1000, then a clean full run must overwrite everything.
    start_run("aborted");
    run_partial("aborted", 1000);
    start_run("full");
    cyc = 3;
    while (!done && cyc < 40000) begin
      @(negedge clk);
      cyc++;
    end
    check("full_done_within_40000", 32'(done), 32'd1);
    if (done) begin
      check("full_last_tag_visible", 32'(ram2[PIX_COUNT - 1]), {26'd0, gold[PIX_COUNT - 1]});
      check("full_all_tags_written", 32'(exp_q.size()), 32'd0);
      drops = 0;
      repeat (30) begin
        @(negedge clk);
        if (!done) drops++;
      end
      check("full_done_held", 32'(drops), 32'd0);
      check("full_silent_after_done", 32'(bad_after_done), 32'd0);
      check("full_tied_outputs", 32'(bad_tie), 32'd0);
      check("full_addr_range", 32'(bad_addr), 32'd0);
      for (int j = 0; j < PIX_COUNT; j++) begin
        if (ram2[j] !== {18'd0, gold[j]}) begin
          n_cmp++;
          n_err++;
          $display("FAIL ram2_final[%0d]: got 0x%0h, expected 0x%0h", j, ram2[j], {18'd0, gold[j]});
        end else begin
          n_cmp++;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
